// File: rtl/spi_word_bridge.sv
// SPI mode-0 target that turns serial frames into parallel words and back.
// All SPI inputs are resynchronised into clk; clk must run at least 8x sclk.
module spi_word_bridge #(
    parameter int WORD_SIZE     = 16,
    parameter int RX_VALID_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 spi_sclk,
    input  logic                 spi_cs_n,
    input  logic                 spi_mosi,
    output logic                 spi_miso,
    output logic [WORD_SIZE-1:0] rx_data,
    output logic                 rx_valid,
    input  logic [WORD_SIZE-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 frame_err,
    output logic [1:0]           fsm_state
);

    localparam int CW = $clog2(WORD_SIZE) + 1;
    localparam int HW = (RX_VALID_HOLD > 0) ? $clog2(RX_VALID_HOLD + 1) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WORD_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SHIFT = 2'd2
    } state_t;

    // tx handshake: a word moves into the holding buffer on any clk edge where
    // tx_valid && tx_ready; tx_ready is high exactly while the buffer is empty.

    state_t state_q, state_d;

    logic sclk_s1, sclk_s2, sclk_d;
    logic cs_s1, cs_s2;
    logic mosi_s1, mosi_s2;
    logic sclk_rise, sclk_fall;

    logic [CW-1:0]        bit_cnt;
    logic [WORD_SIZE-2:0] rx_shift;
    logic [WORD_SIZE-1:0] rx_next;
    logic [WORD_SIZE-1:0] tx_shift;
    logic [WORD_SIZE-1:0] hold_buf;
    logic                 hold_full;
    logic [HW-1:0]        hold_cnt;

    logic do_load, do_clear, do_rx_bit, do_done, do_tx_shift, err_d, capture;

    // cs_n synchronisers reset to "asserted" so a host already holding cs_n low
    // at reset release must deselect before the first frame is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_d  <= 1'b0;
            cs_s1   <= 1'b0;
            cs_s2   <= 1'b0;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            sclk_s1 <= spi_sclk;
            sclk_s2 <= sclk_s1;
            sclk_d  <= sclk_s2;
            cs_s1   <= spi_cs_n;
            cs_s2   <= cs_s1;
            mosi_s1 <= spi_mosi;
            mosi_s2 <= mosi_s1;
        end
    end

    assign sclk_rise = sclk_s2 & ~sclk_d;
    assign sclk_fall = ~sclk_s2 & sclk_d;
    assign rx_next   = {rx_shift, mosi_s2};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The falling edge that follows the last bit is skipped (bit_cnt == 0), so
    // a word reloaded at frame completion keeps its MSB on miso for the next frame.
    always_comb begin
        state_d     = state_q;
        do_load     = 1'b0;
        do_clear    = 1'b0;
        do_rx_bit   = 1'b0;
        do_done     = 1'b0;
        do_tx_shift = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_s2) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (!cs_s2) begin
                    state_d  = SHIFT;
                    do_load  = 1'b1;
                    do_clear = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_s2) begin
                    state_d = ARMED;
                    err_d   = (bit_cnt != '0);
                end else if (sclk_rise) begin
                    do_rx_bit = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        do_done = 1'b1;
                        do_load = 1'b1;
                    end
                end else if (sclk_fall && (bit_cnt != '0)) begin
                    do_tx_shift = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign capture = tx_valid && !hold_full;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            rx_shift  <= '0;
            rx_data   <= '0;
            hold_cnt  <= '0;
            tx_shift  <= '0;
            hold_buf  <= '0;
            hold_full <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= err_d;

            if (do_clear || do_done) begin
                bit_cnt <= '0;
            end else if (do_rx_bit) begin
                bit_cnt <= bit_cnt + CW'(1);
            end

            if (do_rx_bit) begin
                rx_shift <= rx_next[WORD_SIZE-2:0];
            end

            if (do_done) begin
                rx_data  <= rx_next;
                hold_cnt <= HW'(RX_VALID_HOLD);
            end else if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HW'(1);
            end

            if (do_load) begin
                tx_shift <= hold_full ? hold_buf : '0;
            end else if (do_tx_shift) begin
                tx_shift <= {tx_shift[WORD_SIZE-2:0], 1'b0};
            end

            // A load and a capture never coincide on a full buffer, so the
            // loaded word is always the one held before this edge.
            if (capture) begin
                hold_buf  <= tx_data;
                hold_full <= 1'b1;
            end else if (do_load) begin
                hold_full <= 1'b0;
            end
        end
    end

    assign rx_valid  = (hold_cnt != '0);
    assign tx_ready  = ~hold_full;
    assign spi_miso  = (state_q == SHIFT) & tx_shift[WORD_SIZE-1];
    assign fsm_state = state_q;

endmodule
